// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between the control unit (master) and the serial adder (slave).
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Add/sub WIDTH-bit operands through one external 4-bit slice, LSB nibble first; done NIBBLES+1 cycles after start.
// start is ignored while busy (no queuing); SERIAL_ADD_OVF_EN builds the signed-overflow flag, else it is tied 0.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  nibble_serial_adder_ctrl_if.slave bus,
  output logic [3:0] fa_x,
  output logic [3:0] fa_y,
  output logic       fa_cin,
  input  logic [3:0] fa_s,
  input  logic       fa_cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = $clog2(NIBBLES);
  localparam int MSB     = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             accept;
  logic             last;

  assign last = (idx == IDXW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fa_x      = 4'd0;
    fa_y      = 4'd0;
    fa_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        fa_x   = opa[4*idx +: 4];
        fa_y   = opb[4*idx +: 4];
        fa_cin = carry;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // A start in the done cycle chains straight into the next operation.
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert B once and seed the carry with 1.
      opa    <= bus.a;
      opb    <= bus.sub ? ~bus.b : bus.b;
      carry  <= bus.sub;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (state == RUN) begin
      sum_q[4*idx +: 4] <= fa_s;
      carry             <= fa_cout;
      if (last) begin
        idx    <= '0;
        cout_q <= fa_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      ovf_q <= 1'b0;
    else if (accept)
      ovf_q <= 1'b0;
    else if (state == RUN && last)
      ovf_q <= (opa[MSB] == opb[MSB]) & (fa_s[3] != opa[MSB]);
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed bench for nibble_serial_adder_ctrl (WIDTH=32) with a behavioural 4-bit slice.
module tb_nibble_serial_adder_ctrl;
  localparam int W   = 32;
  localparam int NIB = W / 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] fa_x, fa_y, fa_s;
  logic       fa_cin, fa_cout;

  int n_assert = 0;
  int n_fail   = 0;

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .fa_x    (fa_x),
    .fa_y    (fa_y),
    .fa_cin  (fa_cin),
    .fa_s    (fa_s),
    .fa_cout (fa_cout)
  );

  // External ripple-carry slice.
  logic [4:0] slice_res;
  assign slice_res        = {1'b0, fa_x} + {1'b0, fa_y} + {4'd0, fa_cin};
  assign {fa_cout, fa_s}  = slice_res;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result from plain integer arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sub,
                       output logic [31:0] s, output bit c, output bit v);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      s = a - b;
      c = (a >= b);
      r = sa - sb;
    end else begin
      {c, s} = {1'b0, a} + {1'b0, b};
      r = sa + sb;
    end
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifndef SERIAL_ADD_OVF_EN
    v = 1'b0;
`endif
  endtask

  // Carry entering nibble i: the carry out of the low 4*i bits of the full sum.
  function automatic bit carry_into(input logic [31:0] a, input logic [31:0] effb, input bit cin, input int i);
    logic [63:0] m, lo;
    m  = (64'd1 << (4 * i)) - 64'd1;
    lo = ({32'd0, a} & m) + ({32'd0, effb} & m) + {63'd0, cin};
    return lo[4 * i];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'(($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  // pre: start already driven in the previous cycle. glitch: RUN cycle to pulse a stray start.
  // chain: raise start with next operands in the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sub, input bit pre,
                        input int glitch, input bit chain,
                        input logic [31:0] na, input logic [31:0] nb, input bit nsub);
    logic [31:0] es, effb;
    bit          ec, ev;
    model(a, b, sub, es, ec, ev);
    effb = sub ? ~b : b;
    if (!pre) begin
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = sub;
    end
    for (int k = 1; k <= NIB + 1; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == glitch) begin
        bus.start = 1'b1; bus.a = ~a; bus.b = a; bus.sub = ~sub;
      end
      if (k == glitch + 1) bus.start = 1'b0;
      if (k <= NIB) begin
        check("run_busy", 64'(bus.busy), 64'd1);
        check("run_done", 64'(bus.done), 64'd0);
        check("fa_x", 64'(fa_x), 64'(a[4*(k-1) +: 4]));
        check("fa_y", 64'(fa_y), 64'(effb[4*(k-1) +: 4]));
        check("fa_cin", 64'(fa_cin), 64'(carry_into(a, effb, sub, k - 1)));
        if (k == 1) check("sum_cleared", 64'(bus.sum), 64'd0);
      end else begin
        check("done_pulse", 64'(bus.done), 64'd1);
        check("done_busy", 64'(bus.busy), 64'd0);
        check("sum", 64'(bus.sum), 64'(es));
        check("cout", 64'(bus.cout), 64'(ec));
        check("overflow", 64'(bus.overflow), 64'(ev));
        if (chain) begin
          bus.start = 1'b1; bus.a = na; bus.b = nb; bus.sub = nsub;
        end
      end
    end
    if (!chain) begin
      @(negedge clk);
      check("post_done", 64'(bus.done), 64'd0);
      check("post_busy", 64'(bus.busy), 64'd0);
      check("sum_held", 64'(bus.sum), 64'(es));
      check("idle_fa_x", 64'(fa_x), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ca, cb, na, nb;
    bit          cs, ns, ch, pre;

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_fa", 64'({fa_x, fa_y, fa_cin}), 64'd0);
    reset_n = 1'b1;

    // Directed cases
    run_op(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    run_op(32'd5, 32'd7, 1'b1, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    run_op(32'd7, 32'd5, 1'b1, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 3, 1'b0, '0, '0, 1'b0);

    // Reset in RUN cycle 4 discards the partial result
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_done", 64'(bus.done), 64'd0);
    check("mrst_sum", 64'(bus.sum), 64'd0);
    check("mrst_cout", 64'(bus.cout), 64'd0);
    check("mrst_fa", 64'({fa_x, fa_y, fa_cin}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("mrst_idle_busy", 64'(bus.busy), 64'd0);
    check("mrst_idle_done", 64'(bus.done), 64'd0);

    // Back-to-back through the done cycle
    run_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, -1, 1'b1, 32'h0000_0003, 32'h0000_0009, 1'b1);
    run_op(32'h0000_0003, 32'h0000_0009, 1'b1, 1'b1, -1, 1'b0, '0, '0, 1'b0);

    // Randomized operations, some chained
    pre = 1'b0;
    ca  = pick(); cb = pick(); cs = 1'($urandom_range(0, 1));
    for (int i = 0; i < 30; i++) begin
      na = pick(); nb = pick(); ns = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      run_op(ca, cb, cs, pre, -1, ch, na, nb, ns);
      pre = ch;
      ca = na; cb = nb; cs = ns;
    end
    if (pre) run_op(ca, cb, cs, 1'b1, -1, 1'b0, '0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
